// File: rtl/kernel_job_sequencer.sv
// kernel_job_sequencer: job server in front of one start/done style kernel.
// Buffers one pending job, launches the kernel, supervises it with an optional
// timeout and returns each result (or a timeout abort) on a valid/ready port.
module kernel_job_sequencer #(
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [DATA_W-1:0] job_n,
    input  logic [DATA_W-1:0] job_a,
    input  logic [DATA_W-1:0] job_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_timeout,
    output logic              k_r_enable,
    output logic [DATA_W-1:0] k_init_n,
    output logic [DATA_W-1:0] k_init_a,
    output logic [DATA_W-1:0] k_init_b,
    input  logic              k_w_enable,
    input  logic [DATA_W-1:0] k_result,
    output logic              busy,
    output logic [CNT_W-1:0]  jobs_done
);

    // Timeout counter only ever needs to reach TIMEOUT-1.
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;
    localparam bit TMO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               buf_full_q, buf_full_d;
    logic [DATA_W-1:0]  buf_n_q, buf_n_d;
    logic [DATA_W-1:0]  buf_a_q, buf_a_d;
    logic [DATA_W-1:0]  buf_b_q, buf_b_d;
    logic [DATA_W-1:0]  init_n_q, init_n_d;
    logic [DATA_W-1:0]  init_a_q, init_a_d;
    logic [DATA_W-1:0]  init_b_q, init_b_d;
    logic [DATA_W-1:0]  res_data_q, res_data_d;
    logic               res_timeout_q, res_timeout_d;
    logic [CNT_W-1:0]   done_cnt_q, done_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;

    // Kernel runs only in RUN; every other state keeps it parked.
    assign k_r_enable  = (state_q != S_RUN);
    assign job_ready   = ~buf_full_q;
    assign res_valid   = (state_q == S_DONE);
    assign res_data    = res_data_q;
    assign res_timeout = res_timeout_q;
    assign k_init_n    = init_n_q;
    assign k_init_a    = init_a_q;
    assign k_init_b    = init_b_q;
    assign busy        = (state_q != S_IDLE) | buf_full_q;
    assign jobs_done   = done_cnt_q;

    // State and datapath registers; reset parks the kernel and drops all jobs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            buf_full_q    <= 1'b0;
            buf_n_q       <= '0;
            buf_a_q       <= '0;
            buf_b_q       <= '0;
            init_n_q      <= '0;
            init_a_q      <= '0;
            init_b_q      <= '0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
            done_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            buf_full_q    <= buf_full_d;
            buf_n_q       <= buf_n_d;
            buf_a_q       <= buf_a_d;
            buf_b_q       <= buf_b_d;
            init_n_q      <= init_n_d;
            init_a_q      <= init_a_d;
            init_b_q      <= init_b_d;
            res_data_q    <= res_data_d;
            res_timeout_q <= res_timeout_d;
            done_cnt_q    <= done_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    // Next-state logic: buffer enqueue, FSM sequencing, result capture.
    always_comb begin
        state_d       = state_q;
        buf_full_d    = buf_full_q;
        buf_n_d       = buf_n_q;
        buf_a_d       = buf_a_q;
        buf_b_d       = buf_b_q;
        init_n_d      = init_n_q;
        init_a_d      = init_a_q;
        init_b_d      = init_b_q;
        res_data_d    = res_data_q;
        res_timeout_d = res_timeout_q;
        done_cnt_d    = done_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;

        // Enqueue only into an empty buffer; dequeue below only from a full
        // one, so the two never collide in the same cycle.
        if (job_valid && !buf_full_q) begin
            buf_full_d = 1'b1;
            buf_n_d    = job_n;
            buf_a_d    = job_a;
            buf_b_d    = job_b;
        end

        case (state_q)
            S_IDLE: begin
                if (buf_full_q) begin
                    init_n_d   = buf_n_q;
                    init_a_d   = buf_a_q;
                    init_b_d   = buf_b_q;
                    buf_full_d = 1'b0;
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tmo_cnt_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                // Completion is checked first so it wins a tie with timeout.
                if (k_w_enable) begin
                    res_data_d    = k_result;
                    res_timeout_d = 1'b0;
                    state_d       = S_DONE;
                end else if (TMO_EN && (tmo_cnt_q == TMO_LAST)) begin
                    res_data_d    = '0;
                    res_timeout_d = 1'b1;
                    state_d       = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    done_cnt_d = done_cnt_q + CNT_W'(1);
                    if (buf_full_q) begin
                        init_n_d   = buf_n_q;
                        init_a_d   = buf_a_q;
                        init_b_d   = buf_b_q;
                        buf_full_d = 1'b0;
                        state_d    = S_LAUNCH;
                    end else begin
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_kernel_job_sequencer.sv
// Bench for kernel_job_sequencer: two instances (long and short timeout), each
// driving a behavioural kernel that computes a Fibonacci-style recurrence and
// finishes 3*n RUN cycles after launch. Expected results come from a job-level
// reference queue filled at job acceptance.
module tb_kernel_job_sequencer;

    localparam int DW   = 64;
    localparam int CW   = 16;
    localparam int TMO0 = 1024;
    localparam int TMO1 = 16;
    localparam int WAIT_MAX = 300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          job_valid [2];
    logic          job_ready [2];
    logic [DW-1:0] job_n     [2];
    logic [DW-1:0] job_a     [2];
    logic [DW-1:0] job_b     [2];
    logic          res_valid [2];
    logic          res_ready [2];
    logic [DW-1:0] res_data  [2];
    logic          res_timeout [2];
    logic          k_r_enable [2];
    logic [DW-1:0] k_init_n  [2];
    logic [DW-1:0] k_init_a  [2];
    logic [DW-1:0] k_init_b  [2];
    logic          k_w_enable [2];
    logic [DW-1:0] k_result  [2];
    logic          busy      [2];
    logic [CW-1:0] jobs_done [2];
    logic          kw_force  [2];

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW:0] exp_q0 [$];   // {timeout, data}
    logic [DW:0] exp_q1 [$];
    int exp_done [2];

    // Kernel function: n steps of (x, y) <- (y, x + y), result is x.
    function automatic logic [DW-1:0] kfn(input logic [DW-1:0] n, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
        logic [DW-1:0] x = a;
        logic [DW-1:0] y = b;
        logic [DW-1:0] t;
        for (int i = 0; i < int'(n); i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        logic [DW-1:0] kn, ka, kb;
        logic [DW-1:0] kres = '0;
        int            kcnt = 0;
        logic          kw = 1'b0;

        kernel_job_sequencer #(
            .DATA_W (DW),
            .TIMEOUT(gi == 0 ? TMO0 : TMO1),
            .CNT_W  (CW)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .job_valid  (job_valid[gi]),
            .job_ready  (job_ready[gi]),
            .job_n      (job_n[gi]),
            .job_a      (job_a[gi]),
            .job_b      (job_b[gi]),
            .res_valid  (res_valid[gi]),
            .res_ready  (res_ready[gi]),
            .res_data   (res_data[gi]),
            .res_timeout(res_timeout[gi]),
            .k_r_enable (k_r_enable[gi]),
            .k_init_n   (k_init_n[gi]),
            .k_init_a   (k_init_a[gi]),
            .k_init_b   (k_init_b[gi]),
            .k_w_enable (k_w_enable[gi]),
            .k_result   (k_result[gi]),
            .busy       (busy[gi]),
            .jobs_done  (jobs_done[gi])
        );

        // Behavioural kernel: samples operands while parked, raises a sticky
        // done on RUN cycle 3*n, cleared again when parked.
        always @(posedge clk) begin
            if (k_r_enable[gi]) begin
                kn   <= k_init_n[gi];
                ka   <= k_init_a[gi];
                kb   <= k_init_b[gi];
                kcnt <= 0;
                kw   <= 1'b0;
            end else begin
                kcnt <= kcnt + 1;
                if (!kw && (kcnt + 1) == 3 * int'(kn)) begin
                    kw   <= 1'b1;
                    kres <= kfn(kn, ka, kb);
                end
            end
        end
        assign k_w_enable[gi] = kw | kw_force[gi];
        assign k_result[gi]   = kres;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Job-level reference: result known from operands and the timeout limit.
    function automatic void ref_push(input int u, input logic [DW-1:0] n, input logic [DW-1:0] a,
                                     input logic [DW-1:0] b);
        int tmo = (u == 0) ? TMO0 : TMO1;
        bit completes = (tmo == 0) || (3 * int'(n) <= tmo - 1);
        logic [DW:0] e = {~completes, completes ? kfn(n, a, b) : {DW{1'b0}}};
        if (u == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endfunction

    // Offer a job, wait (bounded) for ready, return just after the accept edge.
    task automatic send(input int u, input logic [DW-1:0] n, input logic [DW-1:0] a,
                        input logic [DW-1:0] b);
        int waited = 0;
        job_valid[u] = 1'b1;
        job_n[u] = n;
        job_a[u] = a;
        job_b[u] = b;
        while (!job_ready[u] && waited < WAIT_MAX) begin
            tick();
            waited++;
        end
        chk1("send_ready_wait", waited < WAIT_MAX, 1'b1);
        tick();
        job_valid[u] = 1'b0;
        ref_push(u, n, a, b);
        $display("[TB] inst%0d job accepted n=%0d a=%0h b=%0h", u, n, a, b);
    endtask

    task automatic wait_run(input int u);
        int waited = 0;
        while (k_r_enable[u] && waited < WAIT_MAX) begin
            tick();
            waited++;
        end
        chk1("wait_run", waited < WAIT_MAX, 1'b1);
    endtask

    task automatic cycles_to_valid(input int u, output int cyc);
        cyc = 0;
        while (!res_valid[u] && cyc < WAIT_MAX) begin
            tick();
            cyc++;
        end
    endtask

    // Wait for a result, hold off res_ready for 'hold' cycles, then handshake.
    task automatic recv(input int u, input int hold);
        int waited = 0;
        logic [DW:0] e = '0;
        int qsize = (u == 0) ? exp_q0.size() : exp_q1.size();
        while (!res_valid[u] && waited < WAIT_MAX) begin
            tick();
            waited++;
        end
        chk1("recv_valid_wait", waited < WAIT_MAX, 1'b1);
        chk1("recv_expected_pending", qsize > 0, 1'b1);
        if (qsize > 0) e = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        for (int i = 0; i < hold; i++) begin
            tick();
            chk1("bp_valid", res_valid[u], 1'b1);
            chk("bp_data", res_data[u], e[DW-1:0]);
            chk1("bp_timeout", res_timeout[u], e[DW]);
            chk("bp_jobs_done", 64'(jobs_done[u]), 64'(CW'(exp_done[u])));
        end
        chk("res_data", res_data[u], e[DW-1:0]);
        chk1("res_timeout", res_timeout[u], e[DW]);
        res_ready[u] = 1'b1;
        tick();
        res_ready[u] = 1'b0;
        exp_done[u]++;
        chk("jobs_done", 64'(jobs_done[u]), 64'(CW'(exp_done[u])));
        $display("[TB] inst%0d result data=%0h timeout=%0b jobs_done=%0d", u, e[DW-1:0], e[DW],
                 exp_done[u]);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int u;
        int nsel;
        logic seen;
        for (int i = 0; i < 2; i++) begin
            job_valid[i] = 1'b0;
            res_ready[i] = 1'b0;
            job_n[i] = '0;
            job_a[i] = '0;
            job_b[i] = '0;
            kw_force[i] = 1'b0;
            exp_done[i] = 0;
        end

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_job_ready", job_ready[0], 1'b1);
        chk1("rst_res_valid", res_valid[0], 1'b0);
        chk1("rst_res_timeout", res_timeout[0], 1'b0);
        chk("rst_res_data", res_data[0], 64'd0);
        chk1("rst_k_r_enable", k_r_enable[0], 1'b1);
        chk("rst_k_init_n", k_init_n[0], 64'd0);
        chk("rst_k_init_a", k_init_a[0], 64'd0);
        chk("rst_k_init_b", k_init_b[0], 64'd0);
        chk("rst_jobs_done", 64'(jobs_done[0]), 64'd0);
        chk1("rst_busy", busy[0], 1'b0);
        chk1("rst_busy_inst1", busy[1], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single job: launch timing, operands, 30-cycle kernel, result 55
        send(0, 64'd10, 64'd0, 64'd1);
        chk1("acc_busy", busy[0], 1'b1);
        chk1("acc_job_ready", job_ready[0], 1'b0);
        chk1("acc_k_r_enable", k_r_enable[0], 1'b1);
        tick();
        chk1("launch_k_r_enable", k_r_enable[0], 1'b1);
        chk("launch_init_n", k_init_n[0], 64'd10);
        chk("launch_init_a", k_init_a[0], 64'd0);
        chk("launch_init_b", k_init_b[0], 64'd1);
        chk1("launch_job_ready", job_ready[0], 1'b1);
        tick();
        chk1("run_k_r_enable", k_r_enable[0], 1'b0);
        cycles_to_valid(0, cyc);
        chk("done_latency", 64'(cyc), 64'd31);
        chk("single_result_55", res_data[0], 64'd55);
        recv(0, 0);

        // Back-to-back: second job accepted during RUN, relaunch without IDLE
        send(0, 64'd8, 64'd3, 64'd5);
        wait_run(0);
        send(0, 64'd7, 64'd2, 64'd9);
        chk1("b2b_job_ready_low", job_ready[0], 1'b0);
        chk1("b2b_busy", busy[0], 1'b1);
        recv(0, 0);
        chk1("b2b_launch_k_r_enable", k_r_enable[0], 1'b1);
        chk1("b2b_launch_res_valid", res_valid[0], 1'b0);
        chk("b2b_launch_init_n", k_init_n[0], 64'd7);
        chk("b2b_launch_init_a", k_init_a[0], 64'd2);
        chk("b2b_launch_init_b", k_init_b[0], 64'd9);
        chk1("b2b_job_ready_free", job_ready[0], 1'b1);
        tick();
        chk1("b2b_run_k_r_enable", k_r_enable[0], 1'b0);
        recv(0, 0);

        // Backpressure: result held for 10 cycles
        send(0, 64'd4, 64'd1, 64'd1);
        recv(0, 10);

        // Timeout on the TIMEOUT=16 instance, then a normal job
        send(1, 64'd1000, 64'd0, 64'd1);
        wait_run(1);
        cycles_to_valid(1, cyc);
        chk("timeout_latency", 64'(cyc), 64'd16);
        chk1("timeout_flag", res_timeout[1], 1'b1);
        recv(1, 0);
        send(1, 64'd3, 64'd0, 64'd1);
        recv(1, 0);

        // Tie: done first seen on RUN cycle 15 with TIMEOUT=16
        send(1, 64'd5, 64'd0, 64'd1);
        wait_run(1);
        cycles_to_valid(1, cyc);
        chk("tie_latency", 64'(cyc), 64'd16);
        chk1("tie_timeout_flag", res_timeout[1], 1'b0);
        chk("tie_result", res_data[1], 64'd5);
        recv(1, 0);

        // Randomized jobs on both instances, sometimes two in flight
        for (int it = 0; it < 24; it++) begin
            u = it % 2;
            nsel = $urandom_range(1, 12);
            if ($urandom_range(0, 2) == 0) begin
                send(u, 64'(nsel), {$urandom, $urandom}, {$urandom, $urandom});
                send(u, 64'($urandom_range(1, 12)), {$urandom, $urandom}, {$urandom, $urandom});
                recv(u, $urandom_range(0, 3));
                recv(u, $urandom_range(0, 3));
            end else begin
                send(u, 64'(nsel), {$urandom, $urandom}, {$urandom, $urandom});
                recv(u, $urandom_range(0, 3));
            end
        end

        // Reset mid-RUN with a buffered job; stale done after release
        send(0, 64'd10, 64'd0, 64'd1);
        wait_run(0);
        send(0, 64'd6, 64'd1, 64'd2);
        chk1("pre_rst_job_ready", job_ready[0], 1'b0);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk1("midrst_k_r_enable", k_r_enable[0], 1'b1);
        chk1("midrst_res_valid", res_valid[0], 1'b0);
        chk1("midrst_job_ready", job_ready[0], 1'b1);
        chk1("midrst_busy", busy[0], 1'b0);
        chk("midrst_jobs_done", 64'(jobs_done[0]), 64'd0);
        exp_q0.delete();
        exp_q1.delete();
        exp_done[0] = 0;
        exp_done[1] = 0;
        kw_force[0] = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_valid[0] || busy[0]) seen = 1'b1;
        end
        chk1("stale_kw_no_result", seen, 1'b0);
        kw_force[0] = 1'b0;
        tick();
        send(0, 64'd9, 64'd0, 64'd1);
        recv(0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/kernel_job_sequencer.md
Name: kernel_job_sequencer

Overview:
- Sequences one synthesized kernel instance (start-level `r_enable`, init operands in, sticky `w_enable`/`result` out) as a job server.
- Accepts jobs (n, a, b) on a valid/ready port and buffers one pending job.
- Launches the kernel, waits for completion or timeout, then returns the result on a valid/ready port.
- Sits between the host-side job fabric and the kernel so software never touches kernel start/done timing directly.

Parameters:
DATA_W, 64, width of job operands and result
TIMEOUT, 1024, max RUN cycles before abort; 0 disables timeout
CNT_W, 16, width of completed-job counter

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock; asynchronous, active-low
job_valid  in  1  job offered
job_ready  out  1  job accepted when valid&ready
job_n  in  DATA_W  init_n operand
job_a  in  DATA_W  init_a operand
job_b  in  DATA_W  init_b operand
res_valid  out  1  result available
res_ready  in  1  result consumed when valid&ready
res_data  out  DATA_W  kernel result (0 on timeout)
res_timeout  out  1  result is a timeout abort
k_r_enable  out  1  kernel start/park level
k_init_n  out  DATA_W  kernel init_n
k_init_a  out  DATA_W  kernel init_a
k_init_b  out  DATA_W  kernel init_b
k_w_enable  in  1  kernel done (sticky until next k_r_enable)
k_result  in  DATA_W  kernel result
busy  out  1  state != IDLE or buffer full
jobs_done  out  CNT_W  count of result handshakes, wraps

Behaviour:
- Reset (async assert, sync release) values:
  - state=IDLE, k_r_enable=1 (kernel parked), buffer empty.
  - job_ready=1, res_valid=0, res_timeout=0, res_data=0.
  - k_init_*=0, jobs_done=0, busy=0.
- Job buffer: one entry.
  - job_ready = !buf_full (registered-state derived, no comb path from job_valid).
  - Enqueue on job_valid&job_ready.
  - Accepting a job while RUN/DONE is allowed.
- FSM states: IDLE, LAUNCH, RUN, DONE.
- IDLE:
  - k_r_enable=1.
  - If buf_full: copy buffer into k_init_* regs, free buffer, go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - k_r_enable=1; kernel samples k_init_* at the closing edge.
  - Clear timeout counter, go to RUN.
- RUN:
  - k_r_enable=0; timeout counter increments each cycle.
  - k_w_enable is sampled only in RUN; it is ignored in every other state, including stale-high after reset.
  - On k_w_enable=1: res_data<=k_result, res_timeout<=0, go to DONE.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: res_data<=0, res_timeout<=1, go to DONE.
  - If k_w_enable rises in the same cycle the timeout would fire, completion wins.
- DONE:
  - k_r_enable=1, which re-parks the kernel and clears its w_enable.
  - res_valid=1; res_data and res_timeout are held stable while res_valid & !res_ready.
  - On res_ready: jobs_done+=1 (mod 2^CNT_W).
  - After res_ready, if buf_full: load k_init_* from buffer, free buffer, go directly to LAUNCH. Else go to IDLE.
- Latency:
  - Job accept with idle block → k_r_enable falls 2 cycles later. Path: accept edge, IDLE→LAUNCH edge, LAUNCH→RUN edge.
  - Kernel done (k_w_enable high in RUN) → res_valid high next cycle.
- Timeout counter is sized to hold TIMEOUT-1. It is not used when TIMEOUT=0, where RUN waits forever.
- res_valid never drops without a handshake. No result is dropped or duplicated.
- Reset mid-operation: everything returns to reset values immediately; any pending or running job is discarded; kernel is parked via k_r_enable=1.
- busy = (state!=IDLE) | buf_full.

Test Plan:
- Single job: n=10, a=0, b=1; kernel model asserts w_enable with result 55 after 30 RUN cycles → k_r_enable high for exactly 1 LAUNCH cycle with k_init=(10,0,1); res_valid with res_data=55, res_timeout=0; jobs_done=1.
- Back-to-back: second job offered during RUN of first → job_ready drops after the second accept. Second LAUNCH begins the cycle after the first result handshake, with no IDLE cycle. Results appear in order.
- Backpressure: res_ready low for 10 cycles while DONE → res_data and res_timeout stable, res_valid held, jobs_done unchanged until the handshake.
- Timeout: TIMEOUT=16, kernel never completes → res_valid after 16 RUN cycles with res_timeout=1, res_data=0. Next job still runs correctly.
- Completion/timeout tie: w_enable first high on RUN cycle 15 with TIMEOUT=16 → result reported with res_timeout=0.
- Reset: assert rst_n=0 mid-RUN with one buffered job → immediate k_r_enable=1, res_valid=0, job_ready=1, busy=0. Stale k_w_enable=1 after release produces no result.
